// File: rtl/vcve2_vec_lane_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vcve2_vec_lane_seq                                         |
// | Description : Multi-beat vector element sequencer. Streams LANES x 32-bit |
// |               operand beats through packed SEW8/16/32 add, sub, splat and |
// |               multiply-accumulate lanes, with tail byte masking.          |
// | Option      : define VCVE2_VEC_MAC_EN to build the MAC multipliers;       |
// |               without it op 2'b11 is rejected at start as illegal.        |
// | Revision    : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module vcve2_vec_lane_seq #(
  parameter int LANES = 2,
  parameter int VL_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [2:0]            vsew_i,
  input  logic [VL_W-1:0]       vl_i,
  input  logic [31:0]           scalar_i,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [32*LANES-1:0]   op_a_i,
  input  logic [32*LANES-1:0]   op_b_i,
  input  logic [32*LANES-1:0]   op_c_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [32*LANES-1:0]   res_o,
  output logic [4*LANES-1:0]    res_be_o,
  output logic [VL_W-1:0]       res_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  illegal_o
);

  localparam int NB = 4 * LANES;   // bytes per beat
  localparam int BW = VL_W + 6;    // element-index width, headroom past vl for the last beat

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e              state_q;
  logic [1:0]          op_q;
  logic [1:0]          sew_q;
  logic [VL_W-1:0]     vl_q;
  logic [31:0]         scalar_q;
  logic [VL_W-1:0]     beat_q;
  logic [BW-1:0]       base_q;      // global index of the first element in the current beat
  logic [32*LANES-1:0] res_q;
  logic [NB-1:0]       be_q;
  logic [VL_W-1:0]     idx_q;
  logic                res_valid_q;
  logic                done_q;
  logic                illegal_q;

  logic [BW-1:0]       w_epb;
  logic [BW-1:0]       w_vl_ext;
  logic                w_last;
  logic                w_accept;
  logic                w_start_bad;
  logic [32*LANES-1:0] w_raw;
  logic [32*LANES-1:0] w_res;
  logic [NB-1:0]       w_be;

  // Non-MAC packed arithmetic on one 32-bit word; carries never cross elements.
  function automatic logic [31:0] f_alu(input logic [1:0] op, input logic [1:0] sew,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] s);
    logic [31:0] r;
    r = '0;
    case (sew)
      2'd0: begin
        for (int k = 0; k < 4; k++) begin
          case (op)
            2'b00:   r[k*8 +: 8] = a[k*8 +: 8] + b[k*8 +: 8];
            2'b01:   r[k*8 +: 8] = a[k*8 +: 8] - b[k*8 +: 8];
            2'b10:   r[k*8 +: 8] = s[7:0];
            default: r[k*8 +: 8] = 8'h00;
          endcase
        end
      end
      2'd1: begin
        for (int k = 0; k < 2; k++) begin
          case (op)
            2'b00:   r[k*16 +: 16] = a[k*16 +: 16] + b[k*16 +: 16];
            2'b01:   r[k*16 +: 16] = a[k*16 +: 16] - b[k*16 +: 16];
            2'b10:   r[k*16 +: 16] = s[15:0];
            default: r[k*16 +: 16] = 16'h0000;
          endcase
        end
      end
      2'd2: begin
        case (op)
          2'b00:   r = a + b;
          2'b01:   r = a - b;
          2'b10:   r = s;
          default: r = '0;
        endcase
      end
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef VCVE2_VEC_MAC_EN
  // Packed c + a*b per element, keeping only the low SEW bits of the product.
  function automatic logic [31:0] f_mac(input logic [1:0] sew, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] c);
    logic [31:0] r;
    r = '0;
    case (sew)
      2'd0: begin
        for (int k = 0; k < 4; k++)
          r[k*8 +: 8] = c[k*8 +: 8] + a[k*8 +: 8] * b[k*8 +: 8];
      end
      2'd1: begin
        for (int k = 0; k < 2; k++)
          r[k*16 +: 16] = c[k*16 +: 16] + a[k*16 +: 16] * b[k*16 +: 16];
      end
      2'd2:    r = c + a * b;
      default: r = '0;
    endcase
    return r;
  endfunction
`endif

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [31:0] w_a;
      logic [31:0] w_b;
      assign w_a = op_a_i[l*32 +: 32];
      assign w_b = op_b_i[l*32 +: 32];
`ifdef VCVE2_VEC_MAC_EN
      logic [31:0] w_mac;
      assign w_mac = f_mac(sew_q, w_a, w_b, op_c_i[l*32 +: 32]);
      assign w_raw[l*32 +: 32] = (op_q == 2'b11) ? w_mac : f_alu(op_q, sew_q, w_a, w_b, scalar_q);
`else
      assign w_raw[l*32 +: 32] = f_alu(op_q, sew_q, w_a, w_b, scalar_q);
`endif
    end
  endgenerate

`ifndef VCVE2_VEC_MAC_EN
  // Accumulator input has no consumer without the multipliers.
  logic unused_op_c;
  assign unused_op_c = ^op_c_i;
`endif

  assign w_epb      = BW'(NB) >> sew_q;
  assign w_vl_ext   = {{(BW-VL_W){1'b0}}, vl_q};
  assign w_last     = (base_q + w_epb) >= w_vl_ext;
  assign op_ready_o = (state_q == S_RUN) && (!res_valid_q || res_ready_i);
  assign w_accept   = op_valid_i && op_ready_o;

`ifdef VCVE2_VEC_MAC_EN
  assign w_start_bad = (vsew_i > 3'd2);
`else
  assign w_start_bad = (vsew_i > 3'd2) || (op_i == 2'b11);
`endif

  // Tail mask: a byte is live when its element's global index is below vl.
  always_comb begin
    w_be  = '0;
    w_res = '0;
    for (int j = 0; j < NB; j++) begin
      w_be[j]         = (base_q + (BW'(j) >> sew_q)) < w_vl_ext;
      w_res[j*8 +: 8] = w_be[j] ? w_raw[j*8 +: 8] : 8'h00;
    end
  end

  // Sequencer FSM with the single-entry result register and status pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      sew_q       <= 2'b00;
      vl_q        <= '0;
      scalar_q    <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      res_q       <= '0;
      be_q        <= '0;
      idx_q       <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (w_start_bad) begin
              illegal_q <= 1'b1;
            end else begin
              op_q     <= op_i;
              sew_q    <= vsew_i[1:0];
              vl_q     <= vl_i;
              scalar_q <= scalar_i;
              beat_q   <= '0;
              base_q   <= '0;
              state_q  <= (vl_i == '0) ? S_FIN : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            res_q       <= w_res;
            be_q        <= w_be;
            idx_q       <= beat_q;
            res_valid_q <= 1'b1;
            beat_q      <= beat_q + VL_W'(1);
            base_q      <= base_q + w_epb;
            if (w_last) state_q <= S_DRAIN;
          end else if (res_ready_i) begin
            res_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= S_FIN;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_o       = res_q;
  assign res_be_o    = be_q;
  assign res_idx_o   = idx_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign illegal_o   = illegal_q;

endmodule
`default_nettype wire
